// File: rtl/regwb_pkg.sv
// regwb_pkg: shared types for the write-back sequencer slice.
// The entry layout fixes the data and register-address widths used by the
// load FIFO; the sequencer and its interface default to the same widths.
package regwb_pkg;

    // Default geometry of the register block this sequencer writes into.
    localparam int WB_N         = 16;
    localparam int WB_ADDR_SIZE = 3;
    localparam int WB_REG_COUNT = 8;

    // One queued register-file write: destination register and its value.
    typedef struct packed {
        logic [WB_ADDR_SIZE-1:0] rd;
        logic [WB_N-1:0]         data;
    } wb_entry_t;

    // Which producer owns the write port on a given edge.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM
    } src_e;

endpackage

// File: rtl/regwb_sequencer_if.sv
// regwb_sequencer_if: producer / operand-fetch side of the write-back sequencer.
// Groups the ALU result path, the load handshake, the registered write port,
// the pending flags and the two forwarding taps.  The sequencer connects
// through the slave modport; the surrounding pipeline uses master.
interface regwb_sequencer_if
    import regwb_pkg::*;
#(
    parameter int n         = WB_N,
    parameter int addr_size = WB_ADDR_SIZE,
    parameter int reg_count = WB_REG_COUNT
);

    // ALU result path (always accepted unless stalled)
    logic                 AluValid;
    logic [addr_size-1:0] AluRd;
    logic [n-1:0]         AluData;
    logic                 AluStall;

    // Load result path (valid/ready handshake)
    logic                 MemValid;
    logic                 MemReady;
    logic [addr_size-1:0] MemRd;
    logic [n-1:0]         MemData;

    // Registered register-file write port
    logic                 WE;
    logic [addr_size-1:0] Rw;
    logic [n-1:0]         WData;

    // Hazard information for decode / operand fetch
    logic [reg_count-1:0] Pending;
    logic [addr_size-1:0] Rs1;
    logic [addr_size-1:0] Rs2;
    logic                 Fwd1Hit;
    logic                 Fwd2Hit;
    logic [n-1:0]         Fwd1Data;
    logic [n-1:0]         Fwd2Data;

    modport slave (
        input  AluValid, AluRd, AluData,
        input  MemValid, MemRd, MemData,
        input  Rs1, Rs2,
        output AluStall, MemReady,
        output WE, Rw, WData,
        output Pending,
        output Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data
    );

    modport master (
        output AluValid, AluRd, AluData,
        output MemValid, MemRd, MemData,
        output Rs1, Rs2,
        input  AluStall, MemReady,
        input  WE, Rw, WData,
        input  Pending,
        input  Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data
    );

endinterface

// File: rtl/regwb_fifo.sv
// regwb_fifo: circular queue of pending load write-backs.
// Pointers wrap modulo DEPTH (a power of two); an occupancy count one bit
// wider than the pointers tells full from empty.  Besides the head, the FIFO
// exposes which slots hold live entries and their destination registers so
// the sequencer can build per-register pending flags.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        valid,
    output logic [WB_ADDR_SIZE-1:0] slot_rd [DEPTH]
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    wb_entry_t        mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Advance pointers and occupancy; reset empties the queue, discarding entries.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register here sees pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Capture the pushed entry into the slot under the write pointer.
    // NOTE: storage has no reset; pointers and count alone decide which slots are live.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]   = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            slot_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/regwb_sequencer.sv
// regwb_sequencer: owner of the register block's single write port.
// Each edge it writes at most one result: an ALU result (accepted directly)
// or the head of the load FIFO.  The FIFO is preferred only when idle or when
// the starvation counter has forced a one-cycle ALU stall.  Also publishes
// per-register pending flags and, when REGWB_FORWARD_EN is defined, forwards
// the in-flight write to the two operand read ports (otherwise those outputs
// are tied to zero and Rs1/Rs2 are ignored).
module regwb_sequencer
    import regwb_pkg::*;
#(
    parameter int n          = WB_N,
    parameter int reg_count  = WB_REG_COUNT,
    parameter int addr_size  = WB_ADDR_SIZE,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    regwb_sequencer_if.slave  bus
);

    // Counter range is 0..STARVE_MAX inclusive.
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    // Load FIFO connections
    wb_entry_t                   push_entry;
    wb_entry_t                   fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [DEPTH-1:0]            fifo_valid;
    logic [WB_ADDR_SIZE-1:0]     fifo_slot_rd [DEPTH];

    // Arbitration and anti-starvation
    src_e                        src;
    logic [STARVE_W-1:0]         starve_cnt;
    logic [STARVE_W-1:0]         starve_cnt_next;
    logic                        stall_next;
    logic                        stall_q;

    // Registered write port
    logic                        we_q;
    logic [addr_size-1:0]        rw_q;
    logic [n-1:0]                wdata_q;
    logic [reg_count-1:0]        pending;

    // A load is accepted whenever a slot is free before the edge; a pop on the
    // same edge does not make room for a push that was already refused.
    assign bus.MemReady = !fifo_full;
    assign fifo_push    = bus.MemValid && !fifo_full;
    assign push_entry   = '{rd: bus.MemRd, data: bus.MemData};

    regwb_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .valid      (fifo_valid),
        .slot_rd    (fifo_slot_rd)
    );

    // Pick the source for this edge: forced drain, then ALU, then idle drain.
    always_comb begin
        // NOTE: default first so no path leaves src unassigned (no latch).
        src = SRC_NONE;
        if (stall_q && !fifo_empty) begin
            src = SRC_MEM;
        end else if (bus.AluValid && !stall_q) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_MEM;
        end
    end

    assign fifo_pop = (src == SRC_MEM);

    // Count ALU wins over a waiting load; the STARVE_MAX-th win arms the stall.
    always_comb begin
        starve_cnt_next = '0;
        stall_next      = 1'b0;
        if (src == SRC_ALU && !fifo_empty) begin
            starve_cnt_next = starve_cnt + 1'b1;
            stall_next      = (starve_cnt_next == STARVE_W'(STARVE_MAX));
        end
    end

    // Write port, stall flag and starvation counter; Rw/WData hold when idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            we_q       <= 1'b0;
            rw_q       <= '0;
            wdata_q    <= '0;
            stall_q    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
            stall_q    <= stall_next;
            we_q       <= (src != SRC_NONE);
            case (src)
                SRC_ALU: begin
                    rw_q    <= bus.AluRd;
                    wdata_q <= bus.AluData;
                end
                SRC_MEM: begin
                    rw_q    <= fifo_head.rd;
                    wdata_q <= fifo_head.data;
                end
                default: ;
            endcase
        end
    end

    assign bus.WE       = we_q;
    assign bus.Rw       = rw_q;
    assign bus.WData    = wdata_q;
    assign bus.AluStall = stall_q;

    // A register is pending while a live FIFO entry or the output stage targets it.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) pending[fifo_slot_rd[i]] = 1'b1;
        end
        if (we_q) pending[rw_q] = 1'b1;
    end

    assign bus.Pending = pending;

`ifdef REGWB_FORWARD_EN
    // The output-stage write reaches the register file only after this cycle,
    // so operand fetch takes its value directly on an address match.
    assign bus.Fwd1Hit  = we_q && (rw_q == bus.Rs1);
    assign bus.Fwd2Hit  = we_q && (rw_q == bus.Rs2);
    assign bus.Fwd1Data = wdata_q;
    assign bus.Fwd2Data = wdata_q;
`else
    // Forwarding disabled: taps read as zero and operand addresses are ignored.
    logic unused_rs;
    assign unused_rs    = ^{bus.Rs1, bus.Rs2};
    assign bus.Fwd1Hit  = 1'b0;
    assign bus.Fwd2Hit  = 1'b0;
    assign bus.Fwd1Data = '0;
    assign bus.Fwd2Data = '0;
`endif

endmodule

// File: tb/tb_regwb_sequencer.sv
// tb_regwb_sequencer: directed scenarios followed by randomized traffic.
// A queue-based model of the sequencer is compared against the DUT on every
// falling edge; the directed scenarios add hand-computed expectations.
module tb_regwb_sequencer;

    localparam int N     = 16;
    localparam int AW    = 3;
    localparam int RC    = 8;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;
`ifdef REGWB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    regwb_sequencer_if #(.n(N), .addr_size(AW), .reg_count(RC)) bus ();

    regwb_sequencer #(
        .n(N), .reg_count(RC), .addr_size(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
    } load_t;

    load_t         mq[$];     // loads accepted but not yet written
    logic          m_we;
    logic [AW-1:0] m_rw;
    logic [N-1:0]  m_wdata;
    logic          m_stall;
    int            m_wins;    // consecutive ALU wins while a load waited

    function automatic void model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_rw    = '0;
        m_wdata = '0;
        m_stall = 1'b0;
        m_wins  = 0;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_step();
        bit have     = (mq.size() != 0);
        bit room     = (mq.size() < DEPTH);
        bit from_mem = have && (m_stall || !bus.AluValid);
        bit from_alu = !from_mem && bus.AluValid && !m_stall;
        if (from_alu && have) m_wins++;
        else                  m_wins = 0;
        m_we = from_mem || from_alu;
        if (from_mem) begin
            m_rw    = mq[0].rd;
            m_wdata = mq[0].data;
            void'(mq.pop_front());
        end else if (from_alu) begin
            m_rw    = bus.AluRd;
            m_wdata = bus.AluData;
        end
        if (bus.MemValid && room) mq.push_back('{rd: bus.MemRd, data: bus.MemData});
        m_stall = (m_wins == SMAX);
    endfunction

    function automatic logic [RC-1:0] model_pending();
        logic [RC-1:0] p = '0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_we) p[m_rw] = 1'b1;
        return p;
    endfunction

    // Compare every output against the model mid-cycle, then step the model.
    always @(negedge Clock) begin
        if (Reset) model_reset();
        check("we",        bus.WE,       m_we);
        check("rw",        bus.Rw,       m_rw);
        check("wdata",     bus.WData,    m_wdata);
        check("stall",     bus.AluStall, m_stall);
        check("ready",     bus.MemReady, mq.size() < DEPTH);
        check("pending",   bus.Pending,  model_pending());
        check("fwd1_hit",  bus.Fwd1Hit,  FWD && m_we && (m_rw == bus.Rs1));
        check("fwd2_hit",  bus.Fwd2Hit,  FWD && m_we && (m_rw == bus.Rs2));
        check("fwd1_data", bus.Fwd1Data, FWD ? m_wdata : '0);
        check("fwd2_data", bus.Fwd2Data, FWD ? m_wdata : '0);
        if (!Reset) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.AluValid = 1'b0;
        bus.MemValid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded its time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        bus.AluRd = '0; bus.AluData = '0; bus.MemRd = '0; bus.MemData = '0;
        bus.Rs1 = '0;   bus.Rs2 = '0;
        tick();
        tick();
        check("rst_we",      bus.WE,       0);
        check("rst_rw",      bus.Rw,       0);
        check("rst_wdata",   bus.WData,    0);
        check("rst_stall",   bus.AluStall, 0);
        check("rst_ready",   bus.MemReady, 1);
        check("rst_pending", bus.Pending,  0);
        Reset = 1'b0;
        tick();

        // ALU write and forwarding of the in-flight value
        bus.AluValid = 1'b1; bus.AluRd = 3'd3; bus.AluData = 16'h1234;
        bus.Rs1 = 3'd3; bus.Rs2 = 3'd4;
        tick();
        bus.AluValid = 1'b0;
        check("s1_we",        bus.WE,       1);
        check("s1_rw",        bus.Rw,       3);
        check("s1_wdata",     bus.WData,    16'h1234);
        check("s1_fwd1_hit",  bus.Fwd1Hit,  FWD);
        check("s1_fwd1_data", bus.Fwd1Data, FWD ? 16'h1234 : 16'h0000);
        check("s1_fwd2_hit",  bus.Fwd2Hit,  0);
        tick();
        check("s1_idle_we",   bus.WE,       0);
        check("s1_rw_hold",   bus.Rw,       3);

        // Four loads with no ALU traffic: written in order two edges after push
        for (int k = 1; k <= 4; k++) begin
            bus.MemValid = 1'b1; bus.MemRd = AW'(k); bus.MemData = 16'hA000 + 16'(k);
            tick();
            if (k == 1) begin
                check("s2_latency_we", bus.WE,         0);
                check("s2_pend1",      bus.Pending[1], 1);
            end else begin
                check("s2_we",    bus.WE,    1);
                check("s2_rw",    bus.Rw,    k - 1);
                check("s2_wdata", bus.WData, 16'hA000 + 16'(k - 1));
            end
        end
        bus.MemValid = 1'b0;
        tick();
        check("s2_last_rw", bus.Rw, 4);
        tick();
        check("s2_pending_clear", bus.Pending, 0);
        check("s2_we_clear",      bus.WE,      0);

        // One load to r5 behind continuous ALU traffic
        bus.AluValid = 1'b1; bus.AluRd = 3'd0; bus.AluData = 16'hD000;
        bus.MemValid = 1'b1; bus.MemRd = 3'd5; bus.MemData = 16'hC005;
        tick();
        bus.MemValid = 1'b0;
        check("s3_pend5", bus.Pending[5], 1);
        for (int c = 1; c <= 3; c++) begin
            bus.AluData = 16'hD000 + 16'(c);
            tick();
            check("s3_alu_rw", bus.Rw,       0);
            check("s3_stall",  bus.AluStall, c == 3);
        end
        bus.AluValid = 1'b0;
        tick();
        check("s3_load_rw",    bus.Rw,       5);
        check("s3_load_data",  bus.WData,    16'hC005);
        check("s3_stall_once", bus.AluStall, 0);
        bus.AluValid = 1'b1; bus.AluData = 16'hD004;
        tick();
        check("s3_no_restall", bus.AluStall, 0);
        check("s3_alu_resume", bus.Rw,       0);
        idle();
        tick();

        // Fill the FIFO behind the ALU; a pop while full does not admit a push
        for (int c = 0; c < 4; c++) begin
            bus.AluValid = 1'b1; bus.AluRd = 3'd7; bus.AluData = 16'h7000 + 16'(c);
            bus.MemValid = 1'b1; bus.MemRd = AW'(c + 1); bus.MemData = 16'hB001 + 16'(c);
            tick();
        end
        check("s4_full_ready", bus.MemReady, 0);
        check("s4_stall",      bus.AluStall, 1);
        bus.AluValid = 1'b0; bus.MemRd = 3'd5; bus.MemData = 16'hB005;
        tick();
        check("s4_pop_rw",     bus.Rw,       1);
        check("s4_pop_data",   bus.WData,    16'hB001);
        check("s4_stall_1cyc", bus.AluStall, 0);
        check("s4_ready_back", bus.MemReady, 1);
        bus.AluValid = 1'b1; bus.AluData = 16'h7004;
        tick();
        check("s4_alu_rw",     bus.Rw,       7);
        check("s4_refull",     bus.MemReady, 0);
        idle();
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("s4_drain_rw", bus.Rw, k);
        end
        tick();
        check("s4_pending_clear", bus.Pending, 0);

        // Simultaneous ALU (r2) and load (r6) into an empty FIFO
        bus.AluValid = 1'b1; bus.AluRd = 3'd2; bus.AluData = 16'hE002;
        bus.MemValid = 1'b1; bus.MemRd = 3'd6; bus.MemData = 16'hE006;
        tick();
        idle();
        check("s5_first_rw", bus.Rw,         2);
        check("s5_pend6_a",  bus.Pending[6], 1);
        tick();
        check("s5_second_rw", bus.Rw,         6);
        check("s5_pend6_b",   bus.Pending[6], 1);
        tick();
        check("s5_pending_clear", bus.Pending, 0);

        // Asynchronous reset mid-cycle with three queued loads
        for (int c = 0; c < 3; c++) begin
            bus.AluValid = 1'b1; bus.AluRd = 3'd0; bus.AluData = 16'h5000 + 16'(c);
            bus.MemValid = 1'b1; bus.MemRd = AW'(c + 1); bus.MemData = 16'h6000 + 16'(c);
            tick();
        end
        idle();
        check("s6_queued", bus.Pending[3:1], 3'b111);
        #2;
        Reset = 1'b1;
        #1;
        check("s6_rst_we",      bus.WE,       0);
        check("s6_rst_pending", bus.Pending,  0);
        check("s6_rst_ready",   bus.MemReady, 1);
        check("s6_rst_stall",   bus.AluStall, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("s6_no_stale_we", bus.WE,      0);
            check("s6_no_pending",  bus.Pending, 0);
        end

        // Randomized traffic: busy ALU phase, then a lighter phase
        rdy = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (bus.AluStall) bus.AluValid = ($urandom_range(0, 15) == 0);
            else              bus.AluValid = ($urandom_range(0, 99) < ((c < 1500) ? 75 : 30));
            bus.AluRd   = AW'($urandom);
            bus.AluData = N'($urandom);
            if (!(bus.MemValid && !rdy)) begin
                bus.MemValid = ($urandom_range(0, 99) < ((c < 1500) ? 55 : 35));
                bus.MemRd    = AW'($urandom);
                bus.MemData  = N'($urandom);
            end
            bus.Rs1 = AW'($urandom);
            bus.Rs2 = AW'($urandom);
            rdy = bus.MemReady;
            tick();
        end
        idle();
        repeat (DEPTH + 2) tick();
        check("final_pending", bus.Pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
